// File: rtl/ppheavy_pkg.sv
// ppheavy_pkg: shared state encoding and defaults for the ppheavy sequencer
package ppheavy_pkg;
  localparam int PPH_CNT_W = 6;
  localparam int PPH_CYC_W = 8;
  localparam int PPH_T1 = 20;
  localparam int PPH_T2 = 35;
  typedef enum logic [2:0] {IDLE, ARM, WINDOW, GAP, DONE} state_t;
endpackage

// File: rtl/ppheavy_tick_cnt.sv
// ppheavy_tick_cnt: up-counter that clears and captures a new length on load; tc marks cnt == len-1
module ppheavy_tick_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk_10k,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  logic [CNT_W-1:0] len_q;
  always_ff @(posedge clk_10k or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      len_q <= '0;
    end else begin
      cnt   <= load ? '0 : cnt + CNT_W'(1);
      len_q <= load ? len : len_q;
    end
  end
  assign tc = cnt == len_q - CNT_W'(1);
endmodule

// File: rtl/ppheavy_seq_ctrl.sv
// ppheavy_seq_ctrl: runs cfg_cycles excitation windows with two start pulses each
module ppheavy_seq_ctrl
  import ppheavy_pkg::*;
#(
  parameter int CNT_W = PPH_CNT_W,
  parameter int CYC_W = PPH_CYC_W
) (
  input  logic             clk_10k,
  input  logic             rst,
  input  logic             go,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_t1,
  input  logic [CNT_W-1:0] cfg_t2,
  input  logic [CNT_W-1:0] cfg_win,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [CYC_W-1:0] cfg_cycles,
  output logic             busy,
  output logic             state_start,
  output logic             start,
  output logic [CYC_W-1:0] cycle_cnt,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err
);
  state_t state, state_n;
  logic [CNT_W-1:0] t1_q, t2_q, win_q, gap_q, cnt, len_in;
  logic [CYC_W-1:0] cyc_q, cycle_cnt_n;
  logic cfg_ok, accept, latch, last_win, ld, tc;
  logic start_n, aborted_n, cfg_err_n;
  ppheavy_tick_cnt #(.CNT_W(CNT_W)) u_tick (
    .clk_10k(clk_10k),
    .rst    (rst),
    .load   (ld),
    .len    (len_in),
    .cnt    (cnt),
    .tc     (tc)
  );
  always_comb begin
    cfg_ok = cfg_win >= CNT_W'(2) && cfg_t1 < cfg_t2 && cfg_cycles != '0 &&
             {1'b0, cfg_t2} + (CNT_W+1)'(2) <= {1'b0, cfg_win};
    latch = state == IDLE && go && !abort;
    accept = latch && cfg_ok;
    last_win = cycle_cnt + CYC_W'(1) == cyc_q;
    state_n = state;
    unique case (state)
      IDLE:    state_n = accept ? ARM : IDLE;
      ARM:     state_n = WINDOW;
      WINDOW:  state_n = !tc ? WINDOW : last_win ? DONE : gap_q != '0 ? GAP : WINDOW;
      GAP:     state_n = tc ? WINDOW : GAP;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) state_n = IDLE;
    // the counter restarts whenever a window or gap begins, including back-to-back windows
    ld = (state != WINDOW && state != GAP) || tc;
    len_in = state_n == GAP ? gap_q : win_q;
    start_n = state == WINDOW && !abort && (cnt == t1_q || cnt == t2_q);
    aborted_n = abort && (state == ARM || state == WINDOW || state == GAP);
    cfg_err_n = latch && !cfg_ok;
    cycle_cnt_n = accept ? '0 : (state == WINDOW && tc) ? cycle_cnt + CYC_W'(1) : cycle_cnt;
  end
  always_ff @(posedge clk_10k or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      t1_q        <= '0;
      t2_q        <= '0;
      win_q       <= '0;
      gap_q       <= '0;
      cyc_q       <= '0;
      busy        <= 1'b0;
      state_start <= 1'b0;
      start       <= 1'b0;
      cycle_cnt   <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_n;
      t1_q        <= latch ? cfg_t1 : t1_q;
      t2_q        <= latch ? cfg_t2 : t2_q;
      win_q       <= latch ? cfg_win : win_q;
      gap_q       <= latch ? cfg_gap : gap_q;
      cyc_q       <= latch ? cfg_cycles : cyc_q;
      busy        <= state_n != IDLE;
      state_start <= state_n == WINDOW;
      start       <= start_n;
      cycle_cnt   <= cycle_cnt_n;
      done        <= state_n == DONE;
      aborted     <= aborted_n;
      cfg_err     <= cfg_err_n;
    end
  end
endmodule

// File: tb/tb_ppheavy_seq_ctrl.sv
// tb_ppheavy_seq_ctrl: directed vectors with hand-computed expectations for the ppheavy sequencer
module tb_ppheavy_seq_ctrl;
  import ppheavy_pkg::*;
  logic clk_10k = 0, rst = 1, go = 0, abort = 0;
  logic [5:0] cfg_t1 = 0, cfg_t2 = 0, cfg_win = 0, cfg_gap = 0;
  logic [7:0] cfg_cycles = 0, cycle_cnt;
  logic busy, state_start, start, done, aborted, cfg_err;
  int n_vec = 0, n_err = 0;
  int runs[$], gaps[$], starts[$];
  int n_done, n_abt, n_cfe, stray;
  ppheavy_seq_ctrl dut (
    .clk_10k(clk_10k), .rst(rst), .go(go), .abort(abort),
    .cfg_t1(cfg_t1), .cfg_t2(cfg_t2), .cfg_win(cfg_win), .cfg_gap(cfg_gap),
    .cfg_cycles(cfg_cycles), .busy(busy), .state_start(state_start), .start(start),
    .cycle_cnt(cycle_cnt), .done(done), .aborted(aborted), .cfg_err(cfg_err)
  );
  always #5 clk_10k = ~clk_10k;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] outs();
    return {18'd0, busy, state_start, start, done, aborted, cfg_err, cycle_cnt};
  endfunction
  task automatic set_cfg(input int t1, input int t2, input int win, input int gap, input int cyc);
    cfg_t1 = 6'(t1); cfg_t2 = 6'(t2); cfg_win = 6'(win); cfg_gap = 6'(gap); cfg_cycles = 8'(cyc);
  endtask
  task automatic launch(input int t1, input int t2, input int win, input int gap, input int cyc);
    set_cfg(t1, t2, win, gap, cyc);
    go = 1;
    @(negedge clk_10k);
    go = 0;
  endtask
  task automatic watch(input int budget);
    int run, gapl;
    bit prev, fin;
    runs.delete(); gaps.delete(); starts.delete();
    n_done = 0; n_abt = 0; n_cfe = 0; stray = 0; run = 0; gapl = 0; prev = 0; fin = 0;
    for (int i = 0; i < budget && !fin; i++) begin
      if (state_start) begin
        if (!prev) begin
          if (runs.size() > 0) gaps.push_back(gapl);
          run = 0;
        end
        if (start) starts.push_back(run);
        run++;
      end else begin
        if (prev) begin
          runs.push_back(run);
          gapl = 0;
        end
        if (start) stray++;
        gapl++;
      end
      n_done += int'(done); n_abt += int'(aborted); n_cfe += int'(cfg_err);
      prev = state_start;
      if (!busy) fin = 1;
      else @(negedge clk_10k);
    end
    chk("run_ends", 32'(fin), 1);
  endtask
  task automatic bad_cfg(input string tag, input int t1, input int t2, input int win, input int cyc);
    launch(t1, t2, win, 0, cyc);
    chk({tag, "_err"}, 32'(cfg_err), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    @(negedge clk_10k);
    chk({tag, "_err_once"}, 32'(cfg_err), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask
  initial begin
    int e1[6] = '{21, 36, 21, 36, 21, 36};
    int e2[4] = '{2, 6, 10, 14};
    int rises, acc;
    bit prev;
    repeat (3) @(negedge clk_10k);
    chk("reset_outs", outs(), 0);
    rst = 0;
    @(negedge clk_10k);
    chk("post_reset_outs", outs(), 0);
    // default 20/35 schedule, three windows with gaps
    launch(PPH_T1, PPH_T2, 40, 10, 3);
    watch(300);
    chk("t1_nruns", runs.size(), 3);
    for (int k = 0; k < 3; k++) chk("t1_runlen", runs[k], 40);
    chk("t1_ngaps", gaps.size(), 2);
    for (int k = 0; k < 2; k++) chk("t1_gaplen", gaps[k], 10);
    chk("t1_nstart", starts.size(), 6);
    for (int k = 0; k < 6; k++) chk("t1_startpos", starts[k], e1[k]);
    chk("t1_stray", stray, 0);
    chk("t1_done", n_done, 1);
    chk("t1_abt", n_abt, 0);
    chk("t1_cyc", 32'(cycle_cnt), 3);
    @(negedge clk_10k);
    chk("t1_cyc_hold", 32'(cycle_cnt), 3);
    // back-to-back windows
    launch(1, 5, 8, 0, 2);
    watch(100);
    chk("t2_nruns", runs.size(), 1);
    chk("t2_runlen", runs[0], 16);
    chk("t2_nstart", starts.size(), 4);
    for (int k = 0; k < 4; k++) chk("t2_startpos", starts[k], e2[k]);
    chk("t2_done", n_done, 1);
    chk("t2_cyc", 32'(cycle_cnt), 2);
    bad_cfg("bad_t1eqt2", 5, 5, 8, 1);
    bad_cfg("bad_t2win", 1, 7, 8, 1);
    bad_cfg("bad_cyc0", 1, 5, 8, 0);
    bad_cfg("bad_wrap", 1, 62, 63, 1);
    bad_cfg("bad_win1", 0, 1, 1, 1);
    // abort in window 2, cycle 10
    launch(PPH_T1, PPH_T2, 40, 10, 3);
    rises = 0; prev = 0;
    for (int i = 0; i < 300 && rises < 2; i++) begin
      @(negedge clk_10k);
      if (state_start && !prev) rises++;
      prev = state_start;
    end
    chk("ab_reach_win2", rises, 2);
    repeat (10) @(negedge clk_10k);
    abort = 1;
    @(negedge clk_10k);
    abort = 0;
    chk("ab_ss", 32'(state_start), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_aborted", 32'(aborted), 1);
    chk("ab_cyc", 32'(cycle_cnt), 1);
    acc = int'(done);
    @(negedge clk_10k);
    chk("ab_once", 32'(aborted), 0);
    repeat (3) begin acc += int'(done); @(negedge clk_10k); end
    chk("ab_nodone", acc, 0);
    // go held through a run with config changed after acceptance
    set_cfg(1, 5, 8, 0, 1);
    go = 1;
    @(negedge clk_10k);
    set_cfg(2, 9, 20, 3, 5);
    watch(100);
    go = 0;
    chk("gb_nruns", runs.size(), 1);
    chk("gb_runlen", runs[0], 8);
    chk("gb_nstart", starts.size(), 2);
    chk("gb_cfe", n_cfe, 0);
    chk("gb_done", n_done, 1);
    @(negedge clk_10k);
    chk("gb_idle", 32'(busy), 0);
    // abort with go in idle
    set_cfg(1, 5, 8, 0, 1);
    go = 1; abort = 1;
    @(negedge clk_10k);
    chk("ag_valid_outs", outs(), 32'(1));
    @(negedge clk_10k);
    chk("ag_valid_outs2", outs(), 32'(1));
    set_cfg(1, 5, 8, 0, 0);
    @(negedge clk_10k);
    chk("ag_bad_outs", outs(), 32'(1));
    go = 0; abort = 0;
    // limits
    launch(0, 61, 63, 0, 1);
    watch(100);
    chk("lim_runlen", runs[0], 63);
    chk("lim_nstart", starts.size(), 2);
    chk("lim_start0", starts[0], 1);
    chk("lim_start1", starts[1], 62);
    chk("lim_stray", stray, 0);
    launch(0, 1, 3, 0, 255);
    watch(1000);
    chk("c255_runlen", runs[0], 765);
    chk("c255_nstart", starts.size(), 510);
    chk("c255_done", n_done, 1);
    chk("c255_cyc", 32'(cycle_cnt), 255);
    // async reset mid-window
    launch(1, 5, 8, 0, 3);
    repeat (12) @(negedge clk_10k);
    chk("rst_pre_cyc", 32'(cycle_cnt), 1);
    chk("rst_pre_ss", 32'(state_start), 1);
    #2 rst = 1;
    #1 chk("rst_async_outs", outs(), 0);
    @(negedge clk_10k);
    rst = 0;
    acc = 0;
    repeat (5) begin @(negedge clk_10k); acc += int'(outs() != 0); end
    chk("rst_quiet", acc, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
